aes_core_arbiter: RTL
=====================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning max cycles from core_start to core_done before abort.
REQ-002 Parameter KEY_W, default 256, meaning key bus width; keys left-justified (128-bit key in [255:128], 192-bit key in [255:64]).
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request valid; bit 0 = encrypt driver, bit 1 = decrypt driver.
REQ-006 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-007 req_data0 / req_data1  input  128 each  plaintext (req 0) / ciphertext (req 1).
REQ-008 req_key0 / req_key1  input  KEY_W each  key per requester.
REQ-009 req_klen0 / req_klen1  input  2 each  key length code: 0=128, 1=192, 2=256, 3=invalid.
REQ-010 core_start  output  1  one-cycle start pulse to shared AES core.
REQ-011 core_dec  output  1  0=encrypt, 1=decrypt; equals granted requester index.
REQ-012 core_nk  output  4  key words: 4, 6 or 8.
REQ-013 core_data / core_key  output  128 / KEY_W  latched operands, stable from core_start until the RESP state is left.
REQ-014 core_done  input  1  core result valid pulse.
REQ-015 core_out  input  128  core result.
REQ-016 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-017 rsp_id / rsp_err / rsp_data  output  1 / 1 / 128  requester index, error flag, result.

Function
REQ-018 States: IDLE, START, RUN, RESP; 2-bit encoding from package.
REQ-019 IDLE: req_ready[g]=1 combinationally for arbiter grant g only when req_valid[g]=1; transfer on req_valid[g]&req_ready[g]; latch data, key, klen, id; next state START.
REQ-020 Arbitration: round-robin; sole valid requester wins; both valid -> requester not equal to last_grant wins.
REQ-021 last_grant updates only on the rsp_valid&rsp_ready transfer.
REQ-022 START: core_start=1 for exactly one cycle, timer cleared, next RUN; klen=3 instead skips core (no core_start) and goes RESP with rsp_err=1, rsp_data=0.
REQ-023 RUN: core_done=1 -> capture core_out into rsp_data, rsp_err=0, next RESP; timer==TIMEOUT-1 without core_done -> RESP with rsp_err=1, rsp_data=0.
REQ-024 core_done and timeout in same cycle: done wins, rsp_err=0.
REQ-025 core_done outside RUN: ignored, no state change.
REQ-026 RESP: rsp_valid=1, rsp_id/rsp_err/rsp_data held stable until rsp_ready=1; then IDLE. Back-pressure unbounded.
REQ-027 Latency: accept at cycle T, core_start at T+1, core_done at T+1+n -> rsp_valid at T+2+n; next accept earliest one cycle after response transfer.
REQ-028 req_ready=0 in all states except IDLE; no request queueing.

Reset
REQ-029 reset=0 at posedge: state IDLE, req_ready=0, core_start=0, rsp_valid=0, rsp_err=0, rsp_data=0, timer=0, operand registers 0, last_grant=1 (requester 0 wins first tie).
REQ-030 Reset mid-operation aborts silently: no response issued, pending core_done afterwards ignored.

Structure
REQ-031 Package aes_ctrl_pkg holds state encoding, klen codes and NK constants (4/6/8).
REQ-032 Sub-module rr_arbiter2 (two-way round-robin grant from valid + last_grant); rest in aes_core_arbiter.

Verification
REQ-033 Single req 0, klen=0, core_done 10 cycles after core_start -> core_dec=0, core_nk=4, rsp_valid 11 cycles after core_start, rsp_id=0, rsp_err=0, rsp_data=core_out.
REQ-034 Both requesters valid continuously, 4 ops -> grants 0,1,0,1; rsp_id sequence identical.
REQ-035 req 1, klen=2, core_done never asserted, TIMEOUT=64 -> rsp_valid with rsp_err=1, rsp_data=0 at cycle 64 after core_start.
REQ-036 klen=3 -> no core_start pulse, rsp_err=1 two cycles after accept.
REQ-037 rsp_ready held low 20 cycles -> rsp fields stable, req_ready=0 throughout; req_valid meanwhile not accepted.
REQ-038 reset=0 asserted during RUN, then core_done pulse -> no rsp_valid, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES core arbiter: FSM state encoding,
// key-length codes and the matching AES key-word counts (Nk).
package aes_ctrl_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] KLEN_128 = 2'd0;
  localparam logic [1:0] KLEN_192 = 2'd1;
  localparam logic [1:0] KLEN_256 = 2'd2;
  localparam logic [1:0] KLEN_BAD = 2'd3;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  // Key-length code to key word count; the invalid code maps to 0 and is
  // never presented to the core because no core_start is issued for it.
  function automatic logic [3:0] nk_of(input logic [1:0] klen);
    case (klen)
      KLEN_128: nk_of = NK_128;
      KLEN_192: nk_of = NK_192;
      KLEN_256: nk_of = NK_256;
      default:  nk_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
//   valid      : per-requester request
//   last_grant : requester served most recently
//   grant      : index of the winner (meaningful when grant_vld)
//   grant_vld  : at least one requester is valid
// A lone requester always wins; on a tie the one that was not served
// last wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_vld
);

  always_comb begin
    grant_vld = |valid;
    grant     = 1'b0;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between an encrypt driver (requester 0) and a
// decrypt driver (requester 1). One operation in flight at a time:
// accept -> start core -> wait for done or timeout -> hold response.
//   clk, reset             : clock, synchronous active-low reset
//   req_valid/req_ready    : per-requester request handshake
//   req_data*/key*/klen*   : operands per requester (keys left-justified)
//   core_start/dec/nk      : start pulse and mode to the shared core
//   core_data/core_key     : latched operands, stable for the whole op
//   core_done/core_out     : core result pulse and value
//   rsp_*                  : response handshake with id, error, result
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int KEY_W   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [BLK_W-1:0]  req_data0,
  input  logic [BLK_W-1:0]  req_data1,
  input  logic [KEY_W-1:0]  req_key0,
  input  logic [KEY_W-1:0]  req_key1,
  input  logic [1:0]        req_klen0,
  input  logic [1:0]        req_klen1,
  output logic              core_start,
  output logic              core_dec,
  output logic [3:0]        core_nk,
  output logic [BLK_W-1:0]  core_data,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [BLK_W-1:0]  core_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [BLK_W-1:0]  rsp_data
);

  localparam int TMR_W = $clog2(TIMEOUT + 1) + 1;

  state_t             state, state_nxt;
  logic               grant, grant_vld;
  logic               last_grant;
  logic [BLK_W-1:0]   op_data;
  logic [KEY_W-1:0]   op_key;
  logic [1:0]         op_klen;
  logic               op_id;
  logic [TMR_W-1:0]   timer;
  logic               timed_out;
  logic               accept;
  logic               bad_klen;

  rr_arbiter2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_vld  (grant_vld)
  );

  // The arbiter only grants a valid requester, so being in IDLE with any
  // valid request is exactly the transfer condition.
  assign accept    = (state == ST_IDLE) && grant_vld;
  assign bad_klen  = (op_klen == KLEN_BAD);
  // timer counts cycles since the core_start cycle; >= guards tiny TIMEOUT.
  assign timed_out = (timer >= TMR_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_vld) state_nxt = ST_START;
      ST_START: state_nxt = bad_klen ? ST_RESP : ST_RUN;
      ST_RUN:   if (core_done || timed_out) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[grant] = 1'b1;
    core_start = (state == ST_START) && !bad_klen;
    rsp_valid  = (state == ST_RESP);
  end

  // Operand latch, timer, result capture and round-robin history
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_data    <= '0;
      op_key     <= '0;
      op_klen    <= KLEN_128;
      op_id      <= 1'b0;
      timer      <= '0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (accept) begin
            op_data <= grant ? req_data1 : req_data0;
            op_key  <= grant ? req_key1  : req_key0;
            op_klen <= grant ? req_klen1 : req_klen0;
            op_id   <= grant;
          end
        end
        ST_START: begin
          timer <= timer + TMR_W'(1);
          if (bad_klen) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        end
        ST_RUN: begin
          timer <= timer + TMR_W'(1);
          // done wins over a simultaneous timeout
          if (core_done) begin
            rsp_err  <= 1'b0;
            rsp_data <= core_out;
          end else if (timed_out) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) last_grant <= op_id;
        end
        default: ;
      endcase
    end
  end

  assign core_dec  = op_id;
  assign core_nk   = nk_of(op_klen);
  assign core_data = op_data;
  assign core_key  = op_key;
  assign rsp_id    = op_id;

endmodule
